serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Parallel-to-serial bit-stream transmitter. It is the source side of the team's serial bit-stream detectors.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clk, with a bit-valid strobe and a last-bit marker.
- Also outputs the word's ones count and a "more than one '1'" flag, framed with the bits. Checkers on the detector side use these as expected values.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- GAP, 2, idle cycles (sout=0, sout_valid=0) inserted after each frame (>=0).
- Derived, not overridable: CW = $clog2(WIDTH+1), the width of ones_cnt.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- din  in  WIDTH  word to transmit.
- din_valid  in  1  din is valid.
- din_ready  out  1  block can accept a word; registered.
- sout  out  1  serial data bit; registered.
- sout_valid  out  1  sout carries a frame bit; registered.
- last  out  1  current bit is the final bit of the frame; registered.
- busy  out  1  state != IDLE.
- ones_cnt  out  CW  number of '1's in the frame being sent; held until next accept.
- multi_one  out  1  ones_cnt > 1, qualified by sout_valid.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE.
  - sout, sout_valid, last, busy, ones_cnt, multi_one = 0.
  - Shift register and bit counter cleared.
  - din_ready = 0; it rises at the first clk edge after rst release.
- States: IDLE, SHIFT, GAPW (plus PAR with the optional feature).
- IDLE: din_ready=1. A transfer occurs at the edge where din_valid && din_ready; call this edge T.
  - At T: load the shift register with din; ones_cnt <= popcount(din); din_ready <= 0; state <= SHIFT.
- SHIFT: bit din[WIDTH-1-k] appears on sout with sout_valid=1 during cycle T+1+k, for k=0..WIDTH-1.
  - Latency from accept to first bit is 1 cycle.
  - last=1 only in cycle T+WIDTH.
  - multi_one = (ones_cnt>1) in every cycle where sout_valid=1, and 0 otherwise.
- After the last bit: go to GAPW if GAP>0, otherwise to IDLE.
- GAPW: sout=0, sout_valid=0 for exactly GAP cycles, then IDLE.
  - din_ready is high from cycle T+WIDTH+GAP+1.
  - Earliest next accept is the edge ending that cycle, so the next first bit is at T+WIDTH+GAP+2.
  - With GAP=0 there is exactly one idle cycle between frames.
- din_valid while din_ready=0: ignored. No buffering. din need not be held after the accept edge.
- Counters never wrap.
  - The bit counter runs 0..WIDTH-1 and the GAP counter runs 0..GAP-1; both are cleared on entering their state.
- Reset mid-frame: the frame is aborted immediately, all outputs go to their reset values, and there is no partial completion or resume.
- ones_cnt and multi_one source: ones_cnt reflects the most recently accepted word.
  - multi_one is forced to 0 outside valid bits.

Optional Feature:
- Macro: TX_PARITY_EN.
- Defined: after the last data bit, state PAR emits one extra bit in cycle T+WIDTH+1.
  - The bit is even parity, ^din, with sout_valid=1 and multi_one as for data bits.
  - last moves to the parity cycle.
  - All subsequent timings shift by +1; din_ready is high from T+WIDTH+GAP+2.
- Not defined: no PAR state. The frame is exactly WIDTH bits, as above.

Test Plan:
- Single word, WIDTH=8, GAP=2, no parity: reset, then accept din=8'hA0 at edge T.
  - Required: sout=1,0,1,0,0,0,0,0 in T+1..T+8 with sout_valid=1.
  - last only at T+8; ones_cnt=2; multi_one=1 during T+1..T+8.
  - sout_valid=0 in T+9..T+10; din_ready=1 from T+11.
- Single '1', din=8'h01: sout='1' only at T+8; ones_cnt=1; multi_one=0 throughout.
- Zero word, din=8'h00: 8 valid zero bits; ones_cnt=0; multi_one=0; last at T+8.
- Back-to-back, din_valid held high with 8'hFF then 8'h81, GAP=2:
  - Second accept occurs at the edge ending T+11; its first bit is at T+12.
  - ones_cnt switches 8 -> 2 at that accept.
  - Any din change while busy is ignored.
- Reset mid-frame: drop rst during the 4th bit of 8'hF0.
  - sout, sout_valid, busy and last are 0 immediately, without waiting for clk.
  - din_ready=0 until the first edge after release; a new word then transmits normally from its first bit.
- TX_PARITY_EN defined, din=8'hB5 (five ones):
  - Parity bit 1 at T+9 with sout_valid=1 and last=1.
  - multi_one=1 through T+9; din_ready=1 from T+12.

Source files
------------

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: MSB-first parallel-to-serial frame transmitter with ones count
// Define TX_PARITY_EN to append an even-parity bit (PAR state) to every frame.
module serial_frame_tx #(
    parameter int WIDTH = 8,
    parameter int GAP = 2,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy,
    output logic [CW-1:0]    ones_cnt,
    output logic             multi_one
);
    localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam int GW = GAP > 1 ? $clog2(GAP) : 1;

`ifdef TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, GAPW, PAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, GAPW} state_t;
`endif

    state_t state, state_n;
    logic [BW-1:0] cnt, cnt_n;
    logic [GW-1:0] gcnt, gcnt_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic [CW-1:0] pop, ones_n;
    logic sout_n, sv_n, last_n, rdy_n, acc, done;

    assign acc = din_valid && din_ready;
    assign busy = state != IDLE;
    assign multi_one = sout_valid && ones_cnt > CW'(1);

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) pop = pop + CW'(din[i]);
    end

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        gcnt_n = gcnt;
        sh_n = sh;
        ones_n = ones_cnt;
        sout_n = 1'b0;
        sv_n = 1'b0;
        last_n = 1'b0;
        rdy_n = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: begin
                rdy_n = !acc;
                if (acc) begin
                    state_n = SHIFT;
                    cnt_n = '0;
                    sh_n = din << 1;
                    sout_n = din[WIDTH-1];
                    sv_n = 1'b1;
                    ones_n = pop;
                end
            end
            SHIFT: begin
                if (cnt == BW'(WIDTH - 1)) begin
`ifdef TX_PARITY_EN
                    // even parity of the word equals the LSB of its ones count
                    state_n = PAR;
                    sout_n = ones_cnt[0];
                    sv_n = 1'b1;
                    last_n = 1'b1;
`else
                    done = 1'b1;
`endif
                end else begin
                    cnt_n = cnt + BW'(1);
                    sh_n = sh << 1;
                    sout_n = sh[WIDTH-1];
                    sv_n = 1'b1;
`ifdef TX_PARITY_EN
                    last_n = 1'b0;
`else
                    last_n = cnt == BW'(WIDTH - 2);
`endif
                end
            end
`ifdef TX_PARITY_EN
            PAR: done = 1'b1;
`endif
            GAPW: begin
                state_n = gcnt == GW'(GAP - 1) ? IDLE : GAPW;
                rdy_n = gcnt == GW'(GAP - 1);
                gcnt_n = gcnt + GW'(1);
            end
            default: state_n = IDLE;
        endcase
        if (done) begin
            state_n = GAP > 0 ? GAPW : IDLE;
            gcnt_n = '0;
            rdy_n = GAP == 0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            gcnt <= '0;
            sh <= '0;
            ones_cnt <= '0;
            sout <= 1'b0;
            sout_valid <= 1'b0;
            last <= 1'b0;
            din_ready <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            gcnt <= gcnt_n;
            sh <= sh_n;
            ones_cnt <= ones_n;
            sout <= sout_n;
            sout_valid <= sv_n;
            last <= last_n;
            din_ready <= rdy_n;
        end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: scoreboard bench for serial_frame_tx (WIDTH=8, GAP=2)
// Honours TX_PARITY_EN to expect the extra parity bit and shifted timing.
module tb_serial_frame_tx;
    localparam int W = 8;
    localparam int G = 2;
`ifdef TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct {
        logic b;
        logic l;
        logic m;
        int o;
        int c;
    } exp_t;

    logic clk, rst, din_valid, din_ready, sout, sout_valid, last, busy, multi_one;
    logic [W-1:0] din;
    logic [3:0] ones_cnt;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    exp_t q[$];
    exp_t mon_e;

    serial_frame_tx #(.WIDTH(W), .GAP(G)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .sout(sout), .sout_valid(sout_valid), .last(last), .busy(busy),
        .ones_cnt(ones_cnt), .multi_one(multi_one)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // cycle index c runs from edge c-1 to edge c, so at a negedge the current cycle is cyc+1
    always @(negedge clk) begin
        if (rst) begin
            if (sout_valid) begin
                if (q.size() == 0) chk("extra_bit", sout_valid, 0);
                else begin
                    mon_e = q.pop_front();
                    chk("sout", sout, mon_e.b);
                    chk("last", last, mon_e.l);
                    chk("multi_one", multi_one, mon_e.m);
                    chk("ones_cnt", ones_cnt, mon_e.o);
                    chk("bit_cycle", cyc + 1, mon_e.c);
                end
            end else chk("multi_idle", multi_one, 0);
        end
    end

    task automatic send(input logic [W-1:0] w, input bit hold, output int t);
        int n = 0;
        exp_t e;
        @(negedge clk);
        din = w;
        din_valid = 1'b1;
        while (!din_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", din_ready, 1);
        t = cyc + 1;
        for (int k = 0; k < W; k++) begin
            e.b = w[W-1-k];
            e.l = (P == 0) && (k == W - 1);
            e.m = $countones(w) > 1;
            e.o = $countones(w);
            e.c = t + 1 + k;
            q.push_back(e);
        end
        if (P == 1) begin
            e.b = ^w;
            e.l = 1'b1;
            e.c = t + W + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) din_valid = 1'b0;
    endtask

    task automatic gap_chk(input int t, input logic [W-1:0] w);
        int r = t + W + G + 1 + P;
        do begin
            @(negedge clk);
            chk("din_ready", din_ready, (cyc + 1) >= r);
            chk("busy", busy, (cyc + 1) < r);
            chk("valid_window", sout_valid, (cyc + 1) <= t + W + P);
        end while (cyc + 1 < r);
        chk("ones_held", ones_cnt, $countones(w));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin
        int t, t2, n;
        logic [W-1:0] words[4] = '{8'hA0, 8'h01, 8'h00, 8'hB5};
        rst = 1'b0;
        din = '0;
        din_valid = 1'b0;
        #23;
        chk("rst_sout", sout, 0);
        chk("rst_valid", sout_valid, 0);
        chk("rst_last", last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ones", ones_cnt, 0);
        chk("rst_multi", multi_one, 0);
        chk("rst_ready", din_ready, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("ready_before_edge", din_ready, 0);
        @(negedge clk);
        chk("ready_after_edge", din_ready, 1);
        foreach (words[i]) begin
            send(words[i], 1'b0, t);
            gap_chk(t, words[i]);
        end
        // back-to-back with din_valid held; din changes while busy must be ignored
        send(8'hFF, 1'b1, t);
        din = 8'h3C;
        repeat (3) @(negedge clk);
        send(8'h81, 1'b0, t2);
        chk("b2b_spacing", t2 - t, W + G + 1 + P);
        gap_chk(t2, 8'h81);
        // asynchronous reset during the 4th bit of 8'hF0
        send(8'hF0, 1'b0, t);
        do @(negedge clk); while (cyc + 1 < t + 4);
        #2 rst = 1'b0;
        #1;
        chk("abort_sout", sout, 0);
        chk("abort_valid", sout_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_last", last, 0);
        chk("abort_ones", ones_cnt, 0);
        chk("abort_ready", din_ready, 0);
        q.delete();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rel_ready_before_edge", din_ready, 0);
        @(negedge clk);
        chk("rel_ready_after_edge", din_ready, 1);
        send(8'h3C, 1'b0, t);
        gap_chk(t, 8'h3C);
        n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
